// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter
//   Host-side JTAG shift engine. On a start request it captures a bit count,
//   a TDI word and a TMS word, then clocks them out LSB first on a generated
//   TCK. TDO is sampled at the end of each TCK-high phase and collected into
//   o_tdoData.
//
// Ports
//   i_clk      system clock, all state changes on its rising edge
//   i_rstn     synchronous active-low reset
//   i_start    transaction request, honoured only when idle
//   i_len      number of bits minus one, captured at start
//   i_tdiData  TDI bits, LSB first, captured at start
//   i_tmsData  TMS bits, LSB first, captured at start
//   i_TDO      serial return bit from the target
//   o_TCK      generated JTAG clock (registered)
//   o_TMS      JTAG mode select (registered)
//   o_TDI      JTAG serial data out (registered)
//   o_busy     high while bits are being shifted
//   o_done     one-cycle pulse when a transaction completes
//   o_tdoData  collected TDO bits, bit i = sample of shift bit i
//
// state | meaning
// IDLE  | waiting for i_start; launch flag marks the capture cycle
// LOW   | TCK low, TMS/TDI drive the current bit
// HIGH  | TCK high, TDO sampled on the last cycle
// DONE  | one-cycle completion pulse, all JTAG lines low
module jtag_host_shifter #(
  parameter int HALF_PERIOD = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [4:0]  i_len,
  input  logic [31:0] i_tdiData,
  input  logic [31:0] i_tmsData,
  input  logic        i_TDO,
  output logic        o_TCK,
  output logic        o_TMS,
  output logic        o_TDI,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_tdoData
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} stateT;

  localparam logic [7:0] PHASE_LOAD = 8'(HALF_PERIOD - 1);

  stateT       state, nextState;
  logic        launch;
  logic [4:0]  lenQ;
  logic [31:0] tdiQ, tmsQ;
  logic [4:0]  bitCnt, nextBit;
  logic [7:0]  phaseCnt;
  logic        phaseTc, lastBit, accept;
  logic        tckD, tmsD, tdiD, busyD, doneD;

  assign phaseTc = (phaseCnt == 8'd0);
  assign lastBit = (bitCnt == lenQ);
  // The capture cycle still counts as idle, but a second request there is dropped.
  assign accept  = (state == IDLE) && !launch && i_start;

  // State register plus registered outputs and datapath.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state     <= IDLE;
      launch    <= 1'b0;
      lenQ      <= '0;
      tdiQ      <= '0;
      tmsQ      <= '0;
      bitCnt    <= '0;
      phaseCnt  <= '0;
      o_TCK     <= 1'b0;
      o_TMS     <= 1'b0;
      o_TDI     <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_tdoData <= '0;
    end else begin
      state  <= nextState;
      launch <= accept;
      bitCnt <= nextBit;
      o_TCK  <= tckD;
      o_TMS  <= tmsD;
      o_TDI  <= tdiD;
      o_busy <= busyD;
      o_done <= doneD;
      if (accept) begin
        lenQ      <= i_len;
        tdiQ      <= i_tdiData;
        tmsQ      <= i_tmsData;
        o_tdoData <= '0;
      end
      // Reload on every phase change so the down-counter never wraps.
      if (nextState != state) begin
        phaseCnt <= PHASE_LOAD;
      end else if (!phaseTc) begin
        phaseCnt <= phaseCnt - 8'd1;
      end
      if ((state == HIGH) && phaseTc) begin
        o_tdoData[bitCnt] <= i_TDO;
      end
    end
  end

  always_comb begin
    nextState = state;
    nextBit   = bitCnt;
    case (state)
      IDLE: begin
        nextBit = '0;
        if (launch) nextState = LOW;
      end
      LOW: begin
        if (phaseTc) nextState = HIGH;
      end
      HIGH: begin
        if (phaseTc) begin
          if (lastBit) begin
            nextState = DONE;
          end else begin
            nextState = LOW;
            nextBit   = bitCnt + 5'd1;
          end
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the pins come
  // straight from flops and TMS/TDI only move when a new LOW phase begins.
  always_comb begin
    tckD  = 1'b0;
    tmsD  = 1'b0;
    tdiD  = 1'b0;
    busyD = 1'b0;
    doneD = 1'b0;
    case (nextState)
      LOW: begin
        busyD = 1'b1;
        tmsD  = tmsQ[nextBit];
        tdiD  = tdiQ[nextBit];
      end
      HIGH: begin
        busyD = 1'b1;
        tckD  = 1'b1;
        tmsD  = tmsQ[nextBit];
        tdiD  = tdiQ[nextBit];
      end
      DONE: doneD = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jtag_host_shifter.sv
module tb_jtag_host_shifter;

  localparam int HP = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  len = '0;
  logic [31:0] tdiData = '0;
  logic [31:0] tmsData = '0;
  logic        tdo = 1'b0;
  logic        oTck, oTms, oTdi, oBusy, oDone;
  logic [31:0] tdoData;

  int checks = 0;
  int errors = 0;

  jtag_host_shifter #(.HALF_PERIOD(HP)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_start   (start),
    .i_len     (len),
    .i_tdiData (tdiData),
    .i_tmsData (tmsData),
    .i_TDO     (tdo),
    .o_TCK     (oTck),
    .o_TMS     (oTms),
    .o_TDI     (oTdi),
    .o_busy    (oBusy),
    .o_done    (oDone),
    .o_tdoData (tdoData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pins();
    return {27'b0, oBusy, oTck, oTms, oTdi, oDone};
  endfunction

  // mode 0: TDO tied high, 1: TDO looped from TDI, 2: target returns pat LSB first
  task automatic runTxn(input string tag, input int lenVal, input logic [31:0] tdiVal,
                        input logic [31:0] tmsVal, input int mode, input logic [31:0] pat,
                        input logic [31:0] expTdo, input bit pulse);
    int total;
    int doneCnt;
    int k;
    logic [4:0] expv;
    total   = 2 * HP * (lenVal + 1);
    doneCnt = 0;
    @(posedge clk); #1;
    len     = 5'(lenVal);
    tdiData = tdiVal;
    tmsData = tmsVal;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    for (int c = 1; c <= total + 5; c++) begin
      @(posedge clk); #1;
      k = 0;
      if (c <= total) begin
        k    = (c - 1) / (2 * HP);
        expv = {1'b1, (((c - 1) / HP) % 2) == 1, tmsVal[k], tdiVal[k], 1'b0};
      end else if (c == total + 1) begin
        expv = 5'b00001;
      end else begin
        expv = 5'b00000;
      end
      check($sformatf("%s pins c%0d", tag, c), pins(), {27'b0, expv});
      if (c == total + 1) check($sformatf("%s tdo at done", tag), tdoData, expTdo);
      doneCnt += int'(oDone);
      case (mode)
        0: tdo = 1'b1;
        1: tdo = oTdi;
        default: tdo = pat[k];
      endcase
      start = pulse && (c == 9 || c == total + 1);
    end
    start = 1'b0;
    check($sformatf("%s tdo held", tag), tdoData, expTdo);
    check($sformatf("%s done count", tag), 32'(doneCnt), 32'd1);
  endtask

  initial begin
    logic sticky;

    // reset held 3 cycles with start asserted
    rstn  = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("reset pins", pins(), 32'd0);
      check("reset tdo", tdoData, 32'd0);
    end
    start = 1'b0;
    rstn  = 1'b1;
    @(posedge clk); #1;
    check("idle after reset", pins(), 32'd0);

    runTxn("one bit", 0, 32'h1, 32'h1, 0, 32'h0, 32'h0000_0001, 1'b0);
    runTxn("loop a5", 7, 32'hA5, 32'h80, 1, 32'h0, 32'h0000_00A5, 1'b0);
    runTxn("deadbeef", 31, 32'h1234_5678, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    runTxn("ignore start", 3, 32'h9, 32'h6, 1, 32'h0, 32'h0000_0009, 1'b1);

    // reset in the middle of a len=7 transaction
    @(posedge clk); #1;
    len     = 5'd7;
    tdiData = 32'hFF;
    tmsData = 32'h0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      tdo = oTdi;
    end
    check("pre-abort tdo", tdoData, 32'h0000_0003);
    rstn  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    check("abort pins", pins(), 32'd0);
    check("abort tdo", tdoData, 32'd0);
    rstn  = 1'b1;
    start = 1'b0;
    sticky = 1'b0;
    repeat (70) begin
      @(posedge clk); #1;
      sticky = sticky | oBusy | oDone;
    end
    check("no activity after abort", {31'b0, sticky}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_host_shifter.md
JTAG_HOST_SHIFTER -- requirements
Module: jtag_host_shifter

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 4: i_clk cycles per TCK half-period; legal range 2..255.
REQ-002 SHALL have port i_clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rstn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port i_start  input  1  request a shift transaction; sampled only in IDLE.
REQ-005 SHALL have port i_len  input  5  bit count minus one (0 = 1 bit, 31 = 32 bits); captured at start.
REQ-006 SHALL have port i_tdiData  input  32  TDI bits to send, LSB first; captured at start.
REQ-007 SHALL have port i_tmsData  input  32  TMS bits to send, LSB first; captured at start.
REQ-008 SHALL have port i_TDO  input  1  serial return bit from target.
REQ-009 SHALL have port o_TCK  output  1  generated JTAG clock.
REQ-010 SHALL have port o_TMS  output  1  JTAG mode select.
REQ-011 SHALL have port o_TDI  output  1  JTAG serial data to target.
REQ-012 SHALL have port o_busy  output  1  high while a transaction is in progress.
REQ-013 SHALL have port o_done  output  1  single-cycle pulse at transaction end.
REQ-014 SHALL have port o_tdoData  output  32  captured TDO bits, bit i = sample of shift bit i.

Function
REQ-015 SHALL implement states IDLE, LOW (TCK low, bit driven), HIGH (TCK high), DONE.
REQ-016 SHALL, in IDLE with i_start=1 at edge 0, register i_len/i_tdiData/i_tmsData, clear o_tdoData to 0, and enter LOW at edge 1.
REQ-017 SHALL drive o_TMS/o_TDI with bit k of captured data for all of LOW and HIGH of bit k; they change only on LOW entry.
REQ-018 SHALL hold LOW exactly HALF_PERIOD cycles with o_TCK=0, then HIGH exactly HALF_PERIOD cycles with o_TCK=1.
REQ-019 SHALL sample i_TDO on the last cycle of HIGH into o_tdoData[k]; this margin covers the target's 2-flop input synchronizer.
REQ-020 SHALL, after HIGH of bit k < len, enter LOW of bit k+1; after HIGH of the last bit, enter DONE.
REQ-021 SHALL, in DONE, drive o_TCK=0, o_TMS=0, o_TDI=0, o_done=1 for exactly one cycle, then return to IDLE.
REQ-022 SHALL assert o_busy in LOW and HIGH only; transaction of N bits: o_busy high 2*HALF_PERIOD*N cycles, o_done at cycle 1+2*HALF_PERIOD*N after the start edge.
REQ-023 SHALL ignore i_start while not in IDLE, including in DONE; no queuing.
REQ-024 SHALL leave o_tdoData bits above len at 0 and hold o_tdoData stable from DONE until the next accepted start.
REQ-025 SHALL use a bit counter of 5 bits and a phase counter of 8 bits; the phase counter reloads on every LOW/HIGH transition with no wrap-around glitch.
REQ-026 SHALL drive o_TCK, o_TMS, o_TDI directly from flops (glitch-free).
REQ-027 SHALL, in IDLE, hold o_TCK=0, o_TMS=0, o_TDI=0, o_busy=0, o_done=0.

Reset
REQ-028 SHALL, when i_rstn=0 at a rising edge, enter IDLE and set o_TCK, o_TMS, o_TDI, o_busy, o_done to 0 and o_tdoData to 0x00000000.
REQ-029 SHALL, on reset mid-transaction, abort without o_done and ignore i_start in the reset cycle.
REQ-030 SHALL give reset priority over i_start and all state transitions.

Verification (HALF_PERIOD=4)
REQ-031 SHALL cover: reset held 3 cycles with i_start=1 -> all outputs 0, o_busy never rises.
REQ-032 SHALL cover: start, i_len=0, i_tdiData=1, i_tmsData=1, i_TDO tied 1 -> o_TCK low 4 cycles then high 4 cycles, o_done at cycle 9, o_tdoData=0x00000001.
REQ-033 SHALL cover: start, i_len=7, i_tdiData=0xA5, i_tmsData=0x80, i_TDO looped to o_TDI -> o_TMS high only for bit 7, o_done at cycle 65, o_tdoData=0x000000A5.
REQ-034 SHALL cover: start, i_len=31, target model returning 0xDEADBEEF LSB first -> o_done at cycle 257, o_tdoData=0xDEADBEEF.
REQ-035 SHALL cover: second i_start pulses at cycle 10 and on the o_done cycle of a len=3 transaction -> both ignored, exactly one o_done.
REQ-036 SHALL cover: i_rstn=0 at cycle 20 of a len=7 transaction -> next cycle o_TCK=0, o_busy=0, o_tdoData=0, no o_done.
